// File: rtl/uart_instruction_loader_if.sv
// Instruction-memory halfword write port driven by the boot loader.
// master drives the strobe, address and data; slave is the instruction memory.
interface uart_instruction_loader_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_instruction_loader.sv
// Boot loader: 8N1 UART image receiver writing instruction memory as halfwords; holds CPU until loaded. Optional LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// Latency: wr_en 1 cycle after the high byte's byte_valid; done/cpu_hold 1 cycle after entering DONE.
// Backpressure: none; the serial line cannot be stalled, memory must accept one write per halfword.
module uart_instruction_loader #(
    parameter int CLKS_PER_BIT        = 868,
    parameter int INSTR_ADDRESS_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    uart_instruction_loader_if.master  mem,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       error
);
    localparam int W     = INSTR_ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      CAP     = 17'(2 ** W);

    // ---------------- rx synchroniser ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             byte_vld, byte_vld_nxt;
    logic             frame_err, frame_err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state  <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            byte_vld  <= byte_vld_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        rx_state_nxt  = rx_state;
        clk_cnt_nxt   = clk_cnt + 1'b1;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        byte_vld_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                // Mid-start-bit resample rejects short low glitches.
                if (clk_cnt == HALF_M1) begin
                    clk_cnt_nxt  = '0;
                    bit_idx_nxt  = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_sync, shift[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) byte_vld_nxt  = 1'b1;
                    else         frame_err_nxt = 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- loader FSM ----------------
    typedef enum logic [2:0] {
        LD_LEN_LO, LD_LEN_HI, LD_DATA_LO, LD_DATA_HI, LD_CHECK, LD_DONE, LD_ERROR
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t LD_AFTER_IMG = LD_CHECK;
    logic [7:0] csum, csum_nxt;
`else
    localparam ld_state_t LD_AFTER_IMG = LD_DONE;
`endif

    ld_state_t    ld_state, ld_state_nxt;
    logic [15:0]  count, count_nxt;
    logic [15:0]  count_full;
    logic [W:0]   index, index_nxt, index_inc;
    logic [7:0]   lo, lo_nxt;
    logic         wr_en_q, wr_en_nxt;
    logic [W-1:0] wr_addr_q, wr_addr_nxt;
    logic [15:0]  wr_data_q, wr_data_nxt;

    assign count_full = {shift, count[7:0]};
    assign index_inc  = index + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state  <= LD_LEN_LO;
            count     <= '0;
            index     <= '0;
            lo        <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            ld_state  <= ld_state_nxt;
            count     <= count_nxt;
            index     <= index_nxt;
            lo        <= lo_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
            done      <= (ld_state == LD_DONE);
            cpu_hold  <= (ld_state != LD_DONE);
            error     <= (ld_state == LD_ERROR);
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum_nxt;
`endif
        end
    end

    always_comb begin
        ld_state_nxt = ld_state;
        count_nxt    = count;
        index_nxt    = index;
        lo_nxt       = lo;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr_q;
        wr_data_nxt  = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_nxt     = csum;
`endif
        if (frame_err && ld_state != LD_DONE) begin
            ld_state_nxt = LD_ERROR;
        end else if (byte_vld) begin
            case (ld_state)
                LD_LEN_LO: begin
                    count_nxt    = {8'h00, shift};
                    ld_state_nxt = LD_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt     = csum ^ shift;
`endif
                end
                LD_LEN_HI: begin
                    count_nxt = count_full;
                    index_nxt = '0;
                    if (count_full == 16'd0)           ld_state_nxt = LD_AFTER_IMG;
                    else if ({1'b0, count_full} > CAP) ld_state_nxt = LD_ERROR;
                    else                               ld_state_nxt = LD_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt = csum ^ shift;
`endif
                end
                LD_DATA_LO: begin
                    lo_nxt       = shift;
                    ld_state_nxt = LD_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt     = csum ^ shift;
`endif
                end
                LD_DATA_HI: begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = index[W-1:0];
                    wr_data_nxt  = {shift, lo};
                    index_nxt    = index_inc;
                    ld_state_nxt = (16'(index_inc) == count) ? LD_AFTER_IMG : LD_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt     = csum ^ shift;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHECK: ld_state_nxt = (shift == csum) ? LD_DONE : LD_ERROR;
`endif
                default: ld_state_nxt = ld_state;
            endcase
        end
    end

    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = wr_addr_q;
    assign mem.wr_data = wr_data_q;
endmodule
